keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Matrix-keypad front end that produces the `key` input consumed by the alarm-clock control FSM.
- Scans a 4-row x 3-column keypad and debounces the result.
- Presents a stable 4-bit key code: 0-9 for a digit, NOKEY (10) when no valid key is held.
- Also emits a one-cycle pulse on each newly accepted press.

Parameters:
- SCAN_DIV, 16: clock cycles each row is driven (row dwell); minimum 2.
- DEBOUNCE_CNT, 4: consecutive agreeing scan frames needed to accept a press or a release; minimum 1.

Ports:
- clock  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- col_in  input  3  keypad columns, active-low (0 = key in the driven row closed); externally synchronised.
- row_out  output  4  keypad rows, active-low one-cold drive.
- key  output  4  debounced key code: 0-9, or NOKEY = 10.
- key_press  output  1  one-cycle pulse when a new non-NOKEY code is accepted into `key`.

Behaviour:
- Reset values: row_out = 4'b1110, key = NOKEY, key_press = 0, debounce state = RELEASED, all counters 0.
- Keypad layout (row, col):
  - r0: 1 2 3
  - r1: 4 5 6
  - r2: 7 8 9
  - r3: * 0 #
- Scan:
  - Dwell counter runs 0..SCAN_DIV-1.
  - Row index runs 0..3 and advances, wrapping 3->0, when the dwell counter wraps.
  - row_out drives only the indexed row low.
  - col_in is sampled only on the last dwell cycle of each row (settling time).
  - Frame = 4*SCAN_DIV cycles.
- Frame code, evaluated on the last cycle of row 3:
  - Exactly one closed switch in the whole frame -> its code.
  - Zero closures -> NOKEY.
  - Two or more closures (any rows) -> NOKEY (ghost/multi-key rejection).
  - '*' and '#' -> NOKEY (see Optional Feature).
- Debounce FSM, updated once per frame:
  - RELEASED:
    - frame != NOKEY -> PRESS_DEBOUNCE; cand = frame, cnt = 1.
    - If DEBOUNCE_CNT = 1, go directly to PRESSED and accept.
  - PRESS_DEBOUNCE:
    - frame == cand -> cnt++.
    - cnt reaching DEBOUNCE_CNT -> PRESSED; key = cand; key_press = 1 for that one clock.
    - frame != cand -> RELEASED, cnt = 0.
  - PRESSED:
    - frame == key -> stay.
    - Otherwise (release or a different key) -> RELEASE_DEBOUNCE, cnt = 1.
  - RELEASE_DEBOUNCE:
    - frame == key -> PRESSED.
    - Otherwise cnt++; cnt reaching DEBOUNCE_CNT -> RELEASED, key = NOKEY, no pulse.
- Rolling from one key to another without release: first the full release debounce, then the full press debounce. No direct key-to-key change.
- Latency, press to key update: DEBOUNCE_CNT frames after the first frame showing the key, plus at most 1 frame of alignment. key and key_press are registered and change on the same edge.
- Holding a key never re-pulses key_press. key stays constant while held.
- Counter widths: cnt is sized with $clog2(DEBOUNCE_CNT+1) and saturates; the dwell counter is sized with $clog2(SCAN_DIV).
- Reset asserted mid-frame or mid-debounce: all state returns to reset values on the next clock edge. Scanning restarts at row 0, dwell 0.

Optional Feature:
- Macro: KEYPAD_EXT_KEYS_EN.
- Defined:
  - '*' -> code 11, '#' -> code 12.
  - Both are debounced and pulsed like digits.
- Undefined:
  - '*' and '#' closures are ignored, as if open.
  - They do not count toward multi-key rejection.
  - key is only ever 0-10.

Decomposition:
- Shared package keypad_pkg holds:
  - NOKEY = 10, KEY_STAR = 11, KEY_HASH = 12.
  - Debounce state encodings: RELEASED = 2'b00, PRESS_DEBOUNCE = 2'b01, PRESSED = 2'b10, RELEASE_DEBOUNCE = 2'b11.
  - The row/column-to-code lookup.
- One sub-module, keypad_row_driver:
  - Contains the dwell counter, row index, row_out decode, sample strobe and frame-end strobe.
  - Debounce FSM and frame-code logic stay in the top.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3, frame = 16 cycles):
- Reset release, no keys -> row_out cycles 1110,1101,1011,0111 every 4 clocks; key = 10, key_press never asserts.
- Hold '5' (col_in = 3'b101 while row1 driven) from frame 0 -> key = 5 at end of frame 2, key_press high exactly 1 cycle; key remains 5 over 10 further held frames with no further pulse.
- Bounce '7' present in frames 0,1, absent in frame 2, present in frames 3,4,5 -> key = 7 only at end of frame 5; one pulse.
- '2' and '9' held together for 5 frames -> key stays 10, no pulse; release '9' -> key = 2 after 3 frames.
- Key '0' accepted, then released -> key returns to 10 three frames later; release with a 1-frame re-contact resets the release debounce back to PRESSED.
- Reset asserted during PRESS_DEBOUNCE of '3' -> next edge: row_out = 1110, key = 10; with KEYPAD_EXT_KEYS_EN, holding '#' yields key = 12 after 3 frames, and without it key stays 10.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: key codes, debounce states and
// the row/column-to-code lookup for the 4x3 matrix.
package keypad_pkg;

    localparam logic [3:0] NOKEY    = 4'd10;
    localparam logic [3:0] KEY_STAR = 4'd11;
    localparam logic [3:0] KEY_HASH = 4'd12;

    typedef enum logic [1:0] {
        RELEASED         = 2'b00,
        PRESS_DEBOUNCE   = 2'b01,
        PRESSED          = 2'b10,
        RELEASE_DEBOUNCE = 2'b11
    } deb_state_e;

    // Rows 0-2 hold digits 1-9 in reading order; row 3 is '*', '0', '#'.
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = NOKEY;
        if (row == 2'd3) begin
            case (col)
                2'd0:    code = KEY_STAR;
                2'd1:    code = 4'd0;
                2'd2:    code = KEY_HASH;
                default: code = NOKEY;
            endcase
        end else if (col != 2'd3) begin
            code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_row_driver.sv
// Row scan timing: dwell counter, row index, one-cold active-low row drive,
// a sample strobe on the last dwell cycle and a frame-end strobe on row 3.
module keypad_row_driver #(
    parameter int SCAN_DIV = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic [1:0] row_idx_o,
    output logic [3:0] row_out_o,
    output logic       sample_o,
    output logic       frame_end_o
);

    localparam int             DW         = $clog2(SCAN_DIV);
    localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);

    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    row_q, row_d;
    logic          last_dwell;

    assign last_dwell = (dwell_q == DWELL_LAST);

    always_comb begin
        dwell_d = dwell_q + 1'b1;
        row_d   = row_q;
        if (last_dwell) begin
            dwell_d = '0;
            row_d   = row_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dwell_q <= '0;
            row_q   <= 2'd0;
        end else begin
            dwell_q <= dwell_d;
            row_q   <= row_d;
        end
    end

    assign row_idx_o   = row_q;
    assign row_out_o   = ~(4'b0001 << row_q);
    assign sample_o    = last_dwell;
    assign frame_end_o = last_dwell && (row_q == 2'd3);

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner with per-frame debounce; key/key_press are registered.
// KEYPAD_EXT_KEYS_EN makes '*' (11) and '#' (12) real keys instead of ignored switches.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key,
    output logic       key_press
);

    localparam int            CW      = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CW-1:0] CNT_TGT = CW'(DEBOUNCE_CNT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [1:0] row_idx;
    logic       sample, frame_end;

    keypad_row_driver #(.SCAN_DIV(SCAN_DIV)) u_row_driver (
        .clk_i       (clock),
        .rst_i       (reset),
        .row_idx_o   (row_idx),
        .row_out_o   (row_out),
        .sample_o    (sample),
        .frame_end_o (frame_end)
    );

    logic [2:0] col_en, row_closed;
    logic [1:0] row_hits;
    logic [3:0] row_code;

    // Without extended keys the outer switches of row 3 behave as if open.
`ifdef KEYPAD_EXT_KEYS_EN
    assign col_en = 3'b111;
`else
    assign col_en = (row_idx == 2'd3) ? 3'b010 : 3'b111;
`endif

    assign row_closed = ~col_in & col_en;

    always_comb begin
        row_hits = 2'd0;
        row_code = NOKEY;
        for (int c = 2; c >= 0; c--) begin
            if (row_closed[c]) begin
                row_code = key_code(row_idx, 2'(c));
                if (row_hits != 2'd2) row_hits = row_hits + 2'd1;
            end
        end
    end

    // Closure count saturates at 2: anything above one closure is a reject.
    logic [1:0] hits_q, hits_d;
    logic [3:0] fcode_q, fcode_d;
    logic [2:0] hit_sum;
    logic [3:0] frame_code;

    always_comb begin
        hits_d     = hits_q;
        fcode_d    = fcode_q;
        hit_sum    = {1'b0, hits_q} + {1'b0, row_hits};
        frame_code = NOKEY;
        if (hit_sum == 3'd1) frame_code = (hits_q == 2'd1) ? fcode_q : row_code;
        if (sample) begin
            if (frame_end) begin
                hits_d  = 2'd0;
                fcode_d = NOKEY;
            end else begin
                hits_d = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
                if (hits_q == 2'd0) fcode_d = row_code;
            end
        end
    end

    deb_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    key_q, key_d;
    logic          press_q, press_d;

    assign cnt_inc = (cnt_q >= CNT_TGT) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        key_d   = key_q;
        press_d = 1'b0;
        if (frame_end) begin
            case (state_q)
                RELEASED: begin
                    if (frame_code != NOKEY) begin
                        cand_d = frame_code;
                        if (CNT_ONE >= CNT_TGT) begin
                            state_d = PRESSED;
                            key_d   = frame_code;
                            press_d = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            state_d = PRESS_DEBOUNCE;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                PRESS_DEBOUNCE: begin
                    if (frame_code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= CNT_TGT) begin
                            state_d = PRESSED;
                            key_d   = cand_q;
                            press_d = 1'b1;
                            cnt_d   = '0;
                        end
                    end else begin
                        state_d = RELEASED;
                        cnt_d   = '0;
                    end
                end
                PRESSED: begin
                    if (frame_code != key_q) begin
                        if (CNT_ONE >= CNT_TGT) begin
                            state_d = RELEASED;
                            key_d   = NOKEY;
                            cnt_d   = '0;
                        end else begin
                            state_d = RELEASE_DEBOUNCE;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                RELEASE_DEBOUNCE: begin
                    if (frame_code == key_q) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= CNT_TGT) begin
                            state_d = RELEASED;
                            key_d   = NOKEY;
                            cnt_d   = '0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hits_q  <= 2'd0;
            fcode_q <= NOKEY;
            state_q <= RELEASED;
            cnt_q   <= '0;
            cand_q  <= NOKEY;
            key_q   <= NOKEY;
            press_q <= 1'b0;
        end else begin
            hits_q  <= hits_d;
            fcode_q <= fcode_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            key_q   <= key_d;
            press_q <= press_d;
        end
    end

    assign key       = key_q;
    assign key_press = press_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_CNT=3, 16-cycle frames);
// a switch-matrix model drives col_in from row_out and the set of held keys.
module tb_keypad_scanner;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  col_in;
    logic [3:0]  row_out;
    logic [3:0]  key;
    logic        key_press;
    logic [11:0] held = '0;

    int n_cmp = 0;
    int n_err = 0;
    int pulse_total = 0;

    // Held-key bit index = row*3 + col.
    localparam logic [11:0] B1 = 12'h001, B2 = 12'h002, B3 = 12'h004;
    localparam logic [11:0] B4 = 12'h008, B5 = 12'h010, B6 = 12'h020;
    localparam logic [11:0] B7 = 12'h040, B8 = 12'h080, B9 = 12'h100;
    localparam logic [11:0] BSTAR = 12'h200, B0 = 12'h400, BHASH = 12'h800;

`ifdef KEYPAD_EXT_KEYS_EN
    localparam logic [3:0] E_STAR = 4'd11, E_HASH = 4'd12, E_MIX = 4'd10;
    localparam int         P_EXT = 1, P_MIX = 0;
`else
    localparam logic [3:0] E_STAR = 4'd10, E_HASH = 4'd10, E_MIX = 4'd5;
    localparam int         P_EXT = 0, P_MIX = 1;
`endif

    always #5 clock = ~clock;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clock     (clock),
        .reset     (reset),
        .col_in    (col_in),
        .row_out   (row_out),
        .key       (key),
        .key_press (key_press)
    );

    always_comb begin
        col_in = 3'b111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (!row_out[r] && held[r*3 + c]) col_in[c] = 1'b0;
    end

    always @(negedge clock) if (key_press) pulse_total = pulse_total + 1;

    typedef struct {
        logic [11:0] held;
        int          frames;
        logic [3:0]  exp_key;
        int          exp_pulses;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [11:0] h, input int f, input logic [3:0] k, input int p);
        vec_t v;
        v.held = h; v.frames = f; v.exp_key = k; v.exp_pulses = p;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Entered just after the negedge of a frame's first cycle; returns at the same point.
    task automatic step(input string nm, input logic [11:0] h, input int f,
                        input logic [3:0] ek, input int ep);
        int p0;
        held = h;
        p0 = pulse_total;
        repeat (16 * f) @(posedge clock);
        @(negedge clock);
        #1;
        chk({nm, " key"}, int'(key), int'(ek));
        chk({nm, " pulses"}, pulse_total - p0, ep);
    endtask

    logic [3:0] rows_exp [4];

    initial begin
        rows_exp[0] = 4'b1110; rows_exp[1] = 4'b1101;
        rows_exp[2] = 4'b1011; rows_exp[3] = 4'b0111;

        add(12'h000, 2, 4'd10, 0);
        add(B5,      2, 4'd10, 0);
        add(B5,      1, 4'd5,  1);
        add(B5,     10, 4'd5,  0);
        add(12'h000, 2, 4'd5,  0);
        add(12'h000, 1, 4'd10, 0);
        add(B7,      2, 4'd10, 0);
        add(12'h000, 1, 4'd10, 0);
        add(B7,      2, 4'd10, 0);
        add(B7,      1, 4'd7,  1);
        add(12'h000, 3, 4'd10, 0);
        add(B2 | B9, 5, 4'd10, 0);
        add(B2,      2, 4'd10, 0);
        add(B2,      1, 4'd2,  1);
        add(12'h000, 3, 4'd10, 0);
        add(B0,      3, 4'd0,  1);
        add(12'h000, 1, 4'd0,  0);
        add(B0,      1, 4'd0,  0);
        add(12'h000, 2, 4'd0,  0);
        add(12'h000, 1, 4'd10, 0);
        add(B4 | B5, 3, 4'd10, 0);
        add(B1,      3, 4'd1,  1);
        add(B3,      2, 4'd1,  0);
        add(B3,      1, 4'd10, 0);
        add(B3,      2, 4'd10, 0);
        add(B3,      1, 4'd3,  1);
        add(12'h000, 3, 4'd10, 0);
        add(B6 | B8, 2, 4'd10, 0);
        add(BSTAR,   3, E_STAR, P_EXT);
        add(12'h000, 3, 4'd10, 0);
        add(B5 | BHASH, 3, E_MIX, P_MIX);
        add(12'h000, 3, 4'd10, 0);

        repeat (3) @(posedge clock);
        @(negedge clock);
        #1;
        chk("reset row_out", int'(row_out), int'(4'b1110));
        chk("reset key", int'(key), 10);
        chk("reset key_press", int'(key_press), 0);
        reset = 1'b0;

        // Frame 0: walk the row drive with no keys held.
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("row_out cyc%0d", k), int'(row_out), int'(rows_exp[k / 4]));
            @(posedge clock);
            @(negedge clock);
            #1;
        end

        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("vec%0d", i), tbl[i].held, tbl[i].frames,
                 tbl[i].exp_key, tbl[i].exp_pulses);

        // Reset in the middle of a press debounce of '3'.
        step("pre-reset 3", B3, 2, 4'd10, 0);
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("midreset row_out", int'(row_out), int'(4'b1110));
        chk("midreset key", int'(key), 10);
        chk("midreset key_press", int'(key_press), 0);
        reset = 1'b0;
        step("post-reset 3 a", B3, 2, 4'd10, 0);
        step("post-reset 3 b", B3, 1, 4'd3, 1);
        step("post-reset rel", 12'h000, 3, 4'd10, 0);
        step("hash", BHASH, 3, E_HASH, P_EXT);
        step("hash rel", 12'h000, 3, 4'd10, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
